// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the fetch buffer and its prefetch FIFO:
//   - BUBBLE_WORD  : instruction value handed to decode for an empty slot
//   - PC_INCREMENT : byte distance between sequential instructions
//   - entry_t      : one FIFO entry, an instruction tagged with its PC
//   - fetch_state_t: states of the instruction-memory request FSM
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] BUBBLE_WORD  = ~32'b0;
  localparam int          PC_INCREMENT = 4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] programCounter;
  } entry_t;

  // IDLE    : no request outstanding (FIFO full or PC misaligned)
  // REQUEST : request presented to memory, waiting for busy to drop
  // DISCARD : request made stale by a redirect, draining without a push
  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding prefetched instructions.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write one entry (ignored when full or flushing)
//   pop             drop the head entry (ignored when empty or flushing)
//   flush           empty the FIFO; wins over push and pop
//   head            current head entry (valid when !empty)
//   level           number of stored entries
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  // DEPTH is a power of two, so pointers wrap naturally; a single entry
  // always stays at slot zero.
  function automatic logic [PTR_WIDTH-1:0] advance(input logic [PTR_WIDTH-1:0] ptr);
    return (DEPTH == 1) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= advance(wr_ptr);
      if (do_pop)  rd_ptr <= advance(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_WIDTH'(1);
        2'b01:   level <= level - LEVEL_WIDTH'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pipe_fetch_buffer.sv
// -----------------------------------------------------------------------------
// pipe_fetch_buffer
// Prefetching fetch stage: fetches sequentially into a DEPTH-entry FIFO and
// hands one instruction per pipeline step to decode. Redirects flush the FIFO
// and retarget fetching; a request still busy at redirect time is drained and
// its data thrown away.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   stepPipe, pipeStall         advance strobe and downstream stall
//   redirect, redirectAddress   control-flow change and its target
//   lastInstruction/ProgramCounter  instruction delivered to decode
//   currentPipeStall            last step delivered a bubble
//   addressMisaligned           sticky flag for a misaligned redirect
//   bufferLevel                 FIFO occupancy
//   fetchAddress, fetchEnable   memory request
//   fetchBusy, fetchData        memory response (valid on enable && !busy)
// -----------------------------------------------------------------------------
module pipe_fetch_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH             = 2,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]     PROGRAM_COUNTER_RESET = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] BUBBLE = INSTRUCTION_WIDTH'(BUBBLE_WORD)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stepPipe,
  input  logic                         pipeStall,
  input  logic                         redirect,
  input  logic [ADDRESS_WIDTH-1:0]     redirectAddress,
  output logic [INSTRUCTION_WIDTH-1:0] lastInstruction,
  output logic [ADDRESS_WIDTH-1:0]     lastProgramCounter,
  output logic                         currentPipeStall,
  output logic                         addressMisaligned,
  output logic [$clog2(DEPTH):0]       bufferLevel,
  output logic [ADDRESS_WIDTH-1:0]     fetchAddress,
  output logic                         fetchEnable,
  input  logic                         fetchBusy,
  input  logic [INSTRUCTION_WIDTH-1:0] fetchData
);

  localparam int ENTRY_WIDTH = INSTRUCTION_WIDTH + ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(PC_INCREMENT);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] hold_addr;
  logic                     misaligned;
  logic [ENTRY_WIDTH-1:0]   head_entry;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     completion;
  logic                     accept;
  logic                     step;
  logic                     pop;

  // An outstanding request keeps the enable up regardless of FIFO state, so
  // enable and address stay stable until memory completes. Reset drops the
  // request immediately without waiting for a clock.
  assign fetchEnable  = !rst && ((state != IDLE) || (!fifo_full && !misaligned));
  assign fetchAddress = (state == DISCARD) ? hold_addr : fetch_pc;
  assign completion   = fetchEnable && !fetchBusy;
  assign accept       = completion && (state != DISCARD) && !redirect;
  assign step         = stepPipe && !pipeStall && !redirect;
  assign pop          = step && !fifo_empty;

  assign addressMisaligned = misaligned;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({fetchData, fetch_pc}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_entry),
    .level     (bufferLevel),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request FSM. A redirect while memory is busy moves to DISCARD and parks
  // the old address in hold_addr so the bus stays stable; fetch_pc already
  // points at the new target, which is issued once the stale request drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= PROGRAM_COUNTER_RESET;
      hold_addr  <= '0;
      misaligned <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc   <= redirectAddress;
        misaligned <= |redirectAddress[1:0];
      end else if (accept) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end

      if (fetchEnable && fetchBusy) begin
        if (redirect && (state != DISCARD)) begin
          hold_addr <= fetch_pc;
        end
        state <= (redirect || (state == DISCARD)) ? DISCARD : REQUEST;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Decode-side outputs only move on a step; any step that cannot pop
  // (stall, redirect or empty FIFO) hands decode a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastInstruction    <= BUBBLE;
      lastProgramCounter <= '0;
      currentPipeStall   <= 1'b1;
    end else if (pop) begin
      lastInstruction    <= head_entry[ENTRY_WIDTH-1 -: INSTRUCTION_WIDTH];
      lastProgramCounter <= head_entry[ADDRESS_WIDTH-1:0];
      currentPipeStall   <= 1'b0;
    end else if (stepPipe) begin
      lastInstruction  <= BUBBLE;
      currentPipeStall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_buffer
// Scoreboard bench for pipe_fetch_buffer (DEPTH=2, 32-bit). The driver keeps a
// queue-based reference of the prefetch buffer and pushes the expected decode
// output for every step; a separate monitor pops and compares after each
// stepped clock edge. Memory is a pure function of the address.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_buffer;
  import pipe_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] BUB = ~32'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stepPipe;
  logic        pipeStall;
  logic        redirect;
  logic [31:0] redirectAddress;
  logic [31:0] lastInstruction;
  logic [31:0] lastProgramCounter;
  logic        currentPipeStall;
  logic        addressMisaligned;
  logic [1:0]  bufferLevel;
  logic [31:0] fetchAddress;
  logic        fetchEnable;
  logic        fetchBusy;
  logic [31:0] fetchData;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
  } expect_t;

  expect_t sb[$];
  entry_t  mq[$];

  int compared   = 0;
  int mismatched = 0;

  // reference state
  logic [31:0] next_pc;
  logic [31:0] stale_addr;
  logic [31:0] last_pc;
  logic        mis;
  logic        outstanding;
  logic        stale;

  pipe_fetch_buffer #(
    .DEPTH                 (DEPTH),
    .ADDRESS_WIDTH         (32),
    .INSTRUCTION_WIDTH     (32),
    .PROGRAM_COUNTER_RESET (32'h0),
    .BUBBLE                (BUB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stepPipe           (stepPipe),
    .pipeStall          (pipeStall),
    .redirect           (redirect),
    .redirectAddress    (redirectAddress),
    .lastInstruction    (lastInstruction),
    .lastProgramCounter (lastProgramCounter),
    .currentPipeStall   (currentPipeStall),
    .addressMisaligned  (addressMisaligned),
    .bufferLevel        (bufferLevel),
    .fetchAddress       (fetchAddress),
    .fetchEnable        (fetchEnable),
    .fetchBusy          (fetchBusy),
    .fetchData          (fetchData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign fetchData = mem_word(fetchAddress);

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    next_pc     = 32'h0;
    stale_addr  = 32'h0;
    last_pc     = 32'h0;
    mis         = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
    mq.delete();
  endtask

  // One clock of stimulus: drive inputs, check the memory-side outputs
  // against the reference, then advance the reference across the next edge.
  task automatic apply_stimulus(input logic step, input logic stall, input logic redir,
                                input logic [31:0] raddr, input logic busy);
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        comp;
    entry_t      ent;
    @(negedge clk);
    stepPipe        = step;
    pipeStall       = stall;
    redirect        = redir;
    redirectAddress = raddr;
    fetchBusy       = busy;
    #1;
    exp_en   = outstanding || ((mq.size() < DEPTH) && !mis);
    exp_addr = stale ? stale_addr : next_pc;
    check_output("fetch_enable", 64'(fetchEnable), 64'(exp_en));
    if (exp_en) check_output("fetch_address", 64'(fetchAddress), 64'(exp_addr));
    check_output("buffer_level", 64'(bufferLevel), 64'(mq.size()));
    check_output("address_misaligned", 64'(addressMisaligned), 64'(mis));

    comp = exp_en && !busy;
    if (step) begin
      if (redir || stall || (mq.size() == 0)) begin
        sb.push_back('{instr: BUB, pc: last_pc, stall: 1'b1});
      end else begin
        ent     = mq.pop_front();
        last_pc = ent.programCounter;
        sb.push_back('{instr: ent.instruction, pc: ent.programCounter, stall: 1'b0});
      end
    end
    if (redir) begin
      mq.delete();
      if (exp_en && busy) begin
        if (!stale) stale_addr = exp_addr;
        stale       = 1'b1;
        outstanding = 1'b1;
      end else begin
        stale       = 1'b0;
        outstanding = 1'b0;
      end
      next_pc = raddr;
      mis     = (raddr[1:0] != 2'b00);
    end else if (comp) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        mq.push_back('{instruction: mem_word(next_pc), programCounter: next_pc});
        next_pc = next_pc + 32'd4;
      end
      outstanding = 1'b0;
    end else begin
      outstanding = exp_en && busy;
    end
  endtask

  // Monitor: after every clock edge at which a step was presented, compare
  // the decode outputs against the oldest expected response.
  initial begin
    logic    took;
    expect_t e;
    forever begin
      @(posedge clk);
      took = stepPipe && !rst;
      #1;
      if (took) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard_underflow: got step output, expected none queued at %0t", $time);
        end else begin
          e = sb.pop_front();
          check_output("last_instruction", 64'(lastInstruction), 64'(e.instr));
          check_output("last_program_counter", 64'(lastProgramCounter), 64'(e.pc));
          check_output("current_pipe_stall", 64'(currentPipeStall), 64'(e.stall));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    stepPipe = 1'b0;
    pipeStall = 1'b0;
    redirect = 1'b0;
    redirectAddress = 32'h0;
    fetchBusy = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_last_instruction", 64'(lastInstruction), 64'(BUB));
    check_output("reset_last_pc", 64'(lastProgramCounter), 64'h0);
    check_output("reset_pipe_stall", 64'(currentPipeStall), 64'h1);
    check_output("reset_misaligned", 64'(addressMisaligned), 64'h0);
    check_output("reset_level", 64'(bufferLevel), 64'h0);
    check_output("reset_fetch_enable", 64'(fetchEnable), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // zero-wait fill: addresses 0, 4, then full; first step gives PC 0
    repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // continuous stepping with 3 busy cycles per fetch
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 24; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, (k % 4) != 3);

    // redirect to 0x100 while fetch of 8 is busy
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // misaligned redirect, then recovery via aligned redirect
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // stalled steps with a full FIFO
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // address wrap
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic        r_step;
      logic        r_stall;
      logic        r_redir;
      logic        r_busy;
      logic [31:0] r_addr;
      r_step  = ($urandom_range(0, 9) < 6);
      r_stall = ($urandom_range(0, 9) < 2);
      r_redir = ($urandom_range(0, 19) == 0);
      r_busy  = ($urandom_range(0, 9) < 4);
      r_addr  = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | 32'h2;
      apply_stimulus(r_step, r_stall, r_redir, r_addr, r_busy);
    end

    // reset while a request is busy: enable must drop without a clock
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    stepPipe  = 1'b0;
    redirect  = 1'b0;
    fetchBusy = 1'b1;
    #1;
    check_output("busy_request_enable", 64'(fetchEnable), 64'h1);
    #1 rst = 1'b1;
    #1;
    check_output("async_reset_enable", 64'(fetchEnable), 64'h0);
    check_output("async_reset_instruction", 64'(lastInstruction), 64'(BUB));
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    stepPipe = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #2;
    check_output("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
